// File: rtl/top_pkg.sv
// Shared types and constants for the WEST ping-pong buffer controller.
package top_pkg;

    localparam int TOP_CHUNK_SIZE  = 16;
    localparam int TOP_NUM_MODULES = 4;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } pp_state_e;

    // A bank holds a complete tile once it is FULL and until it is released.
    function automatic logic is_loaded(input pp_state_e s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/pp_bank_fsm.sv
// Lifecycle of one ping-pong bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pp_bank_fsm
    import top_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_acc_i,
    input  logic      fill_done_i,
    input  logic      drain_start_i,
    input  logic      release_i,
    output pp_state_e state_o
);

    pp_state_e state_q, state_d;

    // State register, cleared asynchronously so a reset discards the tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state; fill_done from EMPTY covers a single-row fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (fill_done_i)   state_d = FULL;
                else if (wr_acc_i) state_d = FILLING;
            end
            FILLING:  if (fill_done_i)   state_d = FULL;
            FULL:     if (drain_start_i) state_d = DRAINING;
            DRAINING: if (release_i)     state_d = EMPTY;
            default:  state_d = EMPTY;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/ping_pong_ctrl_w.sv
// WEST ping-pong controller: fills one bank from the producer while the
// other drains in row order to the matmul. Control only, no data path.
module ping_pong_ctrl_w
    import top_pkg::*;
#(
    parameter  int TOTAL_MODULES = TOP_NUM_MODULES,
    parameter  int COL_X         = TOP_CHUNK_SIZE,
    parameter  int RD_PASSES     = 1,
    localparam int ADDR_WIDTH    = $clog2(2 * COL_X),
    localparam int SLICE_W       = $clog2(TOTAL_MODULES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SLICE_W-1:0]    cfg_slice_i,
    output logic [SLICE_W-1:0]    slicing_idx_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  bank0_ena_o,
    output logic                  bank0_enb_o,
    output logic                  bank0_wea_o,
    output logic                  bank0_web_o,
    output logic [ADDR_WIDTH-1:0] bank0_addra_o,
    output logic [ADDR_WIDTH-1:0] bank0_addrb_o,
    output logic                  bank1_ena_o,
    output logic                  bank1_enb_o,
    output logic                  bank1_wea_o,
    output logic                  bank1_web_o,
    output logic [ADDR_WIDTH-1:0] bank1_addra_o,
    output logic [ADDR_WIDTH-1:0] bank1_addrb_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  rd_bank_o,
    output logic                  rd_last_o,
    output logic [1:0]            bank_full_o
);

    localparam int PASS_W = $clog2(RD_PASSES + 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(COL_X - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_OFS   = ADDR_WIDTH'(COL_X);
    localparam logic [PASS_W-1:0]     PASS_LAST = PASS_W'(RD_PASSES - 1);

    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic                  rd_done_q, rd_done_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [SLICE_W-1:0]    slice_q, slice_d;

    pp_state_e             state [2];
    logic [1:0]            wr_acc, fill_done, drain_start, rel, rd_here, en;
    logic [1:0][ADDR_WIDTH-1:0] rowa, rowb;

    logic accept, fill_end, rd_avail, issue, issue_last, consume, release_bank;

    assign in_ready_o   = (state[wr_sel_q] == EMPTY) || (state[wr_sel_q] == FILLING);
    assign accept       = in_valid_i & in_ready_o;
    assign fill_end     = accept & (wr_cnt_q == ROW_LAST);
    assign rd_avail     = is_loaded(state[rd_sel_q]);
    // rd_done holds off further issues while the final row waits to be consumed.
    assign issue        = rd_avail & ~rd_done_q & (~rd_valid_q | rd_ready_i);
    assign issue_last   = issue & (rd_cnt_q == ROW_LAST) & (pass_cnt_q == PASS_LAST);
    assign consume      = rd_valid_q & rd_ready_i;
    assign release_bank = consume & rd_last_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_acc[b]      = accept & (wr_sel_q == 1'(b));
        assign fill_done[b]   = fill_end & (wr_sel_q == 1'(b));
        assign rd_here[b]     = rd_avail & (rd_sel_q == 1'(b));
        assign drain_start[b] = issue & rd_here[b] & (state[b] == FULL);
        assign rel[b]         = release_bank & (rd_sel_q == 1'(b));
        assign en[b]          = wr_acc[b] | (issue & rd_here[b]);
        // Write and read never target the same bank, so the address source
        // follows the bank's role; idle banks park at row 0.
        assign rowa[b] = wr_acc[b]  ? wr_cnt_q :
                         rd_here[b] ? rd_cnt_q : '0;
        assign rowb[b] = wr_acc[b]  ? ROW_OFS + wr_cnt_q :
                         rd_here[b] ? ROW_OFS + rd_cnt_q : '0;
        assign bank_full_o[b] = is_loaded(state[b]);

        pp_bank_fsm u_fsm (
            .clk           (clk),
            .rst_n         (rst_n),
            .wr_acc_i      (wr_acc[b]),
            .fill_done_i   (fill_done[b]),
            .drain_start_i (drain_start[b]),
            .release_i     (rel[b]),
            .state_o       (state[b])
        );
    end

    // Fill side: row counter, fill-bank pointer and slice latched on the first beat.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        slice_d  = slice_q;
        if (accept) begin
            if (state[wr_sel_q] == EMPTY) slice_d = cfg_slice_i;
            if (fill_end) begin
                wr_cnt_d = '0;
                wr_sel_d = ~wr_sel_q;
            end else begin
                wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Drain side: row/pass counters, output-valid tracking and bank release.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        pass_cnt_d = pass_cnt_q;
        rd_done_d  = rd_done_q;
        rd_sel_d   = rd_sel_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_bank_d  = rd_bank_q;
        if (consume) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
        if (issue) begin
            rd_valid_d = 1'b1;
            rd_last_d  = issue_last;
            rd_bank_d  = rd_sel_q;
            if (rd_cnt_q == ROW_LAST) begin
                rd_cnt_d = '0;
                if (pass_cnt_q == PASS_LAST) begin
                    pass_cnt_d = '0;
                    rd_done_d  = 1'b1;
                end else begin
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                end
            end else begin
                rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
            end
        end
        if (release_bank) begin
            rd_done_d = 1'b0;
            rd_sel_d  = ~rd_sel_q;
        end
    end

    // Controller registers; reset abandons any fill or drain in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pass_cnt_q <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            slice_q    <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_done_q  <= rd_done_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_bank_q  <= rd_bank_d;
            slice_q    <= slice_d;
        end
    end

    assign slicing_idx_o = slice_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_last_o     = rd_last_q;
    assign rd_bank_o     = rd_bank_q;

    assign bank0_ena_o   = en[0];
    assign bank0_enb_o   = en[0];
    assign bank0_wea_o   = wr_acc[0];
    assign bank0_web_o   = wr_acc[0];
    assign bank0_addra_o = rowa[0];
    assign bank0_addrb_o = rowb[0];
    assign bank1_ena_o   = en[1];
    assign bank1_enb_o   = en[1];
    assign bank1_wea_o   = wr_acc[1];
    assign bank1_web_o   = wr_acc[1];
    assign bank1_addra_o = rowa[1];
    assign bank1_addrb_o = rowb[1];

endmodule
